// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 scan-code sequencer: pops receiver FIFO bytes, folds E0/F0 prefixes
// into key events, tracks the held key, counts non-repeat makes, latches overflow.
module ps2_kbd_ctrl #(
    parameter int TIMEOUT = 1000000,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       kbd_ready,
    input  logic [7:0] kbd_data,
    input  logic       kbd_overflow,
    output logic       kbd_nextdata_n,
    input  logic       stat_clr,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_repeat,
    output logic       key_down,
    output logic [8:0] held_code,
    output logic [7:0] key_count,
    output logic       overflow_seen
);

    typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

    localparam logic [CNT_W-1:0] TLAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [7:0]       byte_q;
    logic             ext_pend;
    logic             brk_pend;
    logic [CNT_W-1:0] tcnt;
    logic [8:0]       code_full;
    logic             held_hit;

    assign code_full = {ext_pend, byte_q};
    assign held_hit  = (held_code == code_full);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state          <= IDLE;
            byte_q         <= 8'h00;
            ext_pend       <= 1'b0;
            brk_pend       <= 1'b0;
            tcnt           <= '0;
            kbd_nextdata_n <= 1'b1;
            key_valid      <= 1'b0;
            key_code       <= 8'h00;
            key_ext        <= 1'b0;
            key_break      <= 1'b0;
            key_repeat     <= 1'b0;
            key_down       <= 1'b0;
            held_code      <= 9'h000;
            key_count      <= 8'h00;
            overflow_seen  <= 1'b0;
        end else begin
            key_valid     <= 1'b0;
            overflow_seen <= stat_clr ? 1'b0 : (overflow_seen | kbd_overflow);
            case (state)
                IDLE: begin
                    if (kbd_ready) begin
                        byte_q         <= kbd_data;
                        kbd_nextdata_n <= 1'b0;
                        tcnt           <= '0;
                        state          <= POP;
                    end else if (ext_pend || brk_pend) begin
                        // A stranded prefix is dropped so a lost byte cannot corrupt the next key
                        if (tcnt == TLAST) begin
                            ext_pend <= 1'b0;
                            brk_pend <= 1'b0;
                            tcnt     <= '0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end else begin
                        tcnt <= '0;
                    end
                end
                POP: begin
                    kbd_nextdata_n <= 1'b1;
                    state          <= DECODE;
                end
                DECODE: begin
                    state <= IDLE;
                    if (byte_q == 8'hE0) begin
                        ext_pend <= 1'b1;
                    end else if (byte_q == 8'hF0) begin
                        brk_pend <= 1'b1;
                    end else begin
                        key_valid <= 1'b1;
                        key_code  <= byte_q;
                        key_ext   <= ext_pend;
                        key_break <= brk_pend;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                        if (!brk_pend) begin
                            if (key_down && held_hit) begin
                                key_repeat <= 1'b1;
                            end else begin
                                key_repeat <= 1'b0;
                                held_code  <= code_full;
                                key_down   <= 1'b1;
                                key_count  <= key_count + 8'd1;
                            end
                        end else begin
                            key_repeat <= 1'b0;
                            if (held_hit) key_down <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so a clear overrides a same-cycle increment
            if (stat_clr) key_count <= 8'h00;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Randomized and directed bench for ps2_kbd_ctrl with a FIFO model and an
// event-level reference model of the scan-code rules.
module tb_ps2_kbd_ctrl;

    localparam int TO = 16;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rep;
        logic       down;
        logic [8:0] held;
        logic [7:0] cnt;
    } evt_t;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       kbd_ready = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_overflow = 1'b0;
    logic       stat_clr = 1'b0;
    logic       kbd_nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_repeat;
    logic       key_down;
    logic [8:0] held_code;
    logic [7:0] key_count;
    logic       overflow_seen;

    int n_cmp = 0;
    int n_err = 0;
    int nd_lows = 0;
    int nd_run = 0;
    int nd_max_run = 0;
    int vld_cnt = 0;

    logic [7:0] fifo[$];
    evt_t       exp_q[$];
    evt_t       mon_e;

    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       m_down = 1'b0;
    logic [8:0] m_held = 9'h000;
    logic [7:0] m_cnt = 8'h00;

    logic [7:0] pool [7] = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h75, 8'h1B, 8'h23};

    always #5 clk = ~clk;

    ps2_kbd_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .clrn(clrn), .kbd_ready(kbd_ready), .kbd_data(kbd_data),
        .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n),
        .stat_clr(stat_clr), .key_valid(key_valid), .key_code(key_code),
        .key_ext(key_ext), .key_break(key_break), .key_repeat(key_repeat),
        .key_down(key_down), .held_code(held_code), .key_count(key_count),
        .overflow_seen(overflow_seen)
    );

    // Receiver FIFO: pops on the edge that ends the low strobe, emptied by reset
    always @(posedge clk) begin
        if (clrn && !kbd_nextdata_n && fifo.size() != 0) void'(fifo.pop_front());
    end
    always @(negedge clrn) fifo.delete();
    always @(negedge clk) begin
        kbd_ready = (fifo.size() != 0);
        kbd_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (clrn) begin
            if (!kbd_nextdata_n) begin
                nd_lows++;
                nd_run++;
                if (nd_run > nd_max_run) nd_max_run = nd_run;
            end else begin
                nd_run = 0;
            end
            if (key_valid) begin
                vld_cnt++;
                chk("evt_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("evt_code", 32'(key_code), 32'(mon_e.code));
                    chk("evt_ext", 32'(key_ext), 32'(mon_e.ext));
                    chk("evt_break", 32'(key_break), 32'(mon_e.brk));
                    chk("evt_repeat", 32'(key_repeat), 32'(mon_e.rep));
                    chk("evt_down", 32'(key_down), 32'(mon_e.down));
                    chk("evt_held", 32'(held_code), 32'(mon_e.held));
                    chk("evt_count", 32'(key_count), 32'(mon_e.cnt));
                end
            end
        end
    end

    // Reference model: applies the scan-code rules to each byte in arrival order
    task automatic model_byte(input logic [7:0] b);
        evt_t e;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            e.code = b;
            e.ext  = m_ext;
            e.brk  = m_brk;
            if (!m_brk) begin
                if (m_down && m_held == {m_ext, b}) begin
                    e.rep = 1'b1;
                end else begin
                    e.rep  = 1'b0;
                    m_held = {m_ext, b};
                    m_down = 1'b1;
                    m_cnt  = m_cnt + 8'd1;
                end
            end else begin
                e.rep = 1'b0;
                if (m_held == {m_ext, b}) m_down = 1'b0;
            end
            e.down = m_down;
            e.held = m_held;
            e.cnt  = m_cnt;
            exp_q.push_back(e);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        model_byte(b);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pop();
        int k;
        k = 0;
        while (kbd_nextdata_n !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("pop_seen", 32'(kbd_nextdata_n), 32'd0);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || fifo.size() != 0) && k < 5000) begin
            @(posedge clk);
            k++;
        end
        tick(4);
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_nextdata_n"}, 32'(kbd_nextdata_n), 32'd1);
        chk({pfx, "_valid"}, 32'(key_valid), 32'd0);
        chk({pfx, "_code"}, 32'(key_code), 32'd0);
        chk({pfx, "_flags"}, 32'({key_ext, key_break, key_repeat, key_down}), 32'd0);
        chk({pfx, "_held"}, 32'(held_code), 32'd0);
        chk({pfx, "_count"}, 32'(key_count), 32'd0);
        chk({pfx, "_overflow"}, 32'(overflow_seen), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_pops;
        int base_vld;
        tick(3);
        chk_reset("por");
        clrn = 1'b1;
        tick(2);

        // Single make: latency and resulting state
        base_pops = nd_lows;
        push_byte(8'h1C);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_latency", 32'(key_valid), 32'd1);
        wait_drain();
        chk("t1_pops", 32'(nd_lows - base_pops), 32'd1);
        chk("t1_held", 32'(held_code), 32'h01C);
        chk("t1_count", 32'(key_count), 32'd1);

        // Typematic repeats and release
        push_byte(8'h1C); push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
        wait_drain();
        chk("t2_down", 32'(key_down), 32'd0);
        chk("t2_count_a", 32'(key_count), 32'd1);
        push_byte(8'h1C);
        wait_drain();
        chk("t2_count_b", 32'(key_count), 32'd2);

        // Extended press/release
        base_pops = nd_lows;
        base_vld  = vld_cnt;
        push_byte(8'hE0); push_byte(8'h75); push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
        wait_drain();
        chk("t3_pops", 32'(nd_lows - base_pops), 32'd5);
        chk("t3_valids", 32'(vld_cnt - base_vld), 32'd2);
        chk("t3_held", 32'(held_code), 32'h175);
        chk("t3_down", 32'(key_down), 32'd0);

        // Prefix timeout: long gap drops F0, short gap keeps it
        push_byte(8'hF0);
        wait_pop();
        @(posedge clk);
        tick(1);
        tick(TO + 2);
        m_ext = 1'b0;
        m_brk = 1'b0;
        push_byte(8'h1C);
        wait_drain();
        chk("t4_long_down", 32'(key_down), 32'd1);
        push_byte(8'hF0);
        wait_pop();
        @(posedge clk);
        tick(1);
        tick(TO - 3);
        push_byte(8'h1C);
        wait_drain();
        chk("t4_short_brk", 32'(key_break), 32'd1);

        // Random byte stream with short gaps
        for (int i = 0; i < 150; i++) begin
            push_byte(pool[$urandom_range(0, 6)]);
            tick($urandom_range(0, 3));
        end
        if (m_ext || m_brk) push_byte(8'h23);
        wait_drain();

        // Count wrap after 256 non-repeat makes
        stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0;
        m_cnt = 8'h00;
        chk("t6_clr", 32'(key_count), 32'd0);
        push_byte(8'h4A);
        for (int i = 0; i < 255; i++) push_byte(i[0] ? 8'h32 : 8'h1C);
        wait_drain();
        chk("t6_wrap", 32'(key_count), 32'd0);

        // stat_clr during DECODE of a make beats the increment
        push_byte(8'h32);
        m_cnt = 8'h00;
        exp_q[$].cnt = 8'h00;
        wait_pop();
        @(posedge clk);
        #1 stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0;
        wait_drain();
        chk("t6_clr_win", 32'(key_count), 32'd0);

        // Sticky overflow
        kbd_overflow = 1'b1;
        tick(1);
        kbd_overflow = 1'b0;
        tick(3);
        chk("t7_ovf_set", 32'(overflow_seen), 32'd1);
        tick(10);
        chk("t7_ovf_hold", 32'(overflow_seen), 32'd1);
        stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0;
        chk("t7_ovf_clr", 32'(overflow_seen), 32'd0);

        // Reset during POP with a pending prefix and queued bytes
        fifo.push_back(8'hF0); fifo.push_back(8'h1B); fifo.push_back(8'h23);
        wait_pop();
        @(posedge clk);
        tick(1);
        wait_pop();
        #1 clrn = 1'b0;
        #1 chk_reset("mid");
        m_ext = 1'b0; m_brk = 1'b0; m_down = 1'b0; m_held = 9'h000; m_cnt = 8'h00;
        exp_q.delete();
        tick(2);
        clrn = 1'b1;
        tick(2);
        push_byte(8'h1B);
        wait_drain();
        chk("t8_count", 32'(key_count), 32'd1);
        chk("t8_held", 32'(held_code), 32'h01B);
        chk("t8_brk", 32'(key_break), 32'd0);

        chk("nd_max_run", 32'(nd_max_run), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
